// File: rtl/game_cmd_arbiter.sv
// Purpose: shares the 8-bit in_bits game link between the manual controller
//          and the script engine. One requester is granted at a time. Its
//          command is held on the link for a bounded time and then followed
//          by a forced idle gap.
// Latency: the grant is seen one cycle after the IDLE evaluation edge, and
//          in_bits carries the command from that same cycle. The release
//          (done) shows one cycle after the exit edge.
// Backpressure: requests are levels. A losing or late request simply stays
//          pending, and nothing is queued. Requests are ignored outside IDLE.
// Ports:
//   clk, rst            clock, async active-high reset
//   mode_sel            00 manual-only, 01 auto-only, 10 manual priority,
//                       11 round-robin
//   man_req/man_cmd     manual request level and command byte
//   man_gnt/man_done    manual grant / finish pulses
//   auto_req/auto_cmd   script request level and command byte
//   auto_gnt/auto_done  script grant / finish pulses
//   in_bits             byte driven onto the game link
//   busy                arbiter not idle
//   owner               current or last grantee (0 manual, 1 auto)
//   timeout             with done, when MAX_HOLD cut the drive short
module game_cmd_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_HOLD    = 255,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_sel,
  input  logic       man_req,
  input  logic [7:0] man_cmd,
  output logic       man_gnt,
  output logic       man_done,
  input  logic       auto_req,
  input  logic [7:0] auto_cmd,
  output logic       auto_gnt,
  output logic       auto_done,
  output logic [7:0] in_bits,
  output logic       busy,
  output logic       owner,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] MAX_LAST  = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] gap_cnt;

  logic       man_elig;
  logic       auto_elig;
  logic       pick_auto;
  logic [7:0] win_cmd;
  logic       owner_req;
  logic       normal_exit;

  // Arbitration is only acted upon in IDLE. In round-robin mode the
  // requester that was not served last wins a tie.
  always_comb begin
    man_elig  = man_req && (mode_sel != 2'b01);
    auto_elig = auto_req && (mode_sel != 2'b00);
    if (man_elig && auto_elig)
      pick_auto = (mode_sel == 2'b11) ? ~owner : 1'b0;
    else
      pick_auto = auto_elig;
  end

  assign win_cmd     = pick_auto ? auto_cmd : man_cmd;
  assign owner_req   = owner ? auto_req : man_req;
  // A normal release takes priority over the limit when both apply on one edge.
  assign normal_exit = (hold_cnt >= HOLD_LAST) && !owner_req;

  // in_bits doubles as the latched command register. Requester cmd changes
  // after the grant never reach the link.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      in_bits   <= 8'h00;
      man_gnt   <= 1'b0;
      man_done  <= 1'b0;
      auto_gnt  <= 1'b0;
      auto_done <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b1;
    end else begin
      man_gnt   <= 1'b0;
      man_done  <= 1'b0;
      auto_gnt  <= 1'b0;
      auto_done <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (man_elig || auto_elig) begin
            owner <= pick_auto;
            busy  <= 1'b1;
            if (pick_auto) auto_gnt <= 1'b1;
            else           man_gnt  <= 1'b1;
            if (win_cmd[1:0] == 2'b00) begin
              // Null command: nothing to drive. Finish at once, but still
              // enforce the gap.
              state   <= GAP;
              gap_cnt <= '0;
              if (pick_auto) auto_done <= 1'b1;
              else           man_done  <= 1'b1;
            end else begin
              state    <= DRIVE;
              hold_cnt <= '0;
              in_bits  <= win_cmd;
            end
          end
        end
        DRIVE: begin
          if (normal_exit || hold_cnt == MAX_LAST) begin
            state   <= GAP;
            gap_cnt <= '0;
            in_bits <= 8'h00;
            timeout <= !normal_exit;
            if (owner) auto_done <= 1'b1;
            else       man_done  <= 1'b1;
          end else if (hold_cnt != CNT_SAT) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          in_bits <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_cmd_arbiter.sv
// Bench for game_cmd_arbiter: two instances share one stimulus. One uses the
// default MAX_HOLD and the other uses MAX_HOLD=8. Each is compared every cycle
// against a transaction-level expectation built from the request waveforms.
module tb_game_cmd_arbiter;
  localparam int N    = 64;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  typedef struct packed {
    logic [7:0] ib;
    logic       mg;
    logic       md;
    logic       ag;
    logic       ad;
    logic       busy;
    logic       own;
    logic       to;
  } ob_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode_sel = 2'b00;
  logic       man_req = 1'b0, auto_req = 1'b0;
  logic [7:0] man_cmd = 8'h00, auto_cmd = 8'h00;

  logic [7:0] ib [2];
  logic       mg [2], md [2], ag [2], ad [2], bz [2], ow [2], to [2];

  game_cmd_arbiter dut0 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .man_req(man_req), .man_cmd(man_cmd), .man_gnt(mg[0]), .man_done(md[0]),
    .auto_req(auto_req), .auto_cmd(auto_cmd), .auto_gnt(ag[0]), .auto_done(ad[0]),
    .in_bits(ib[0]), .busy(bz[0]), .owner(ow[0]), .timeout(to[0])
  );

  game_cmd_arbiter #(.MAX_HOLD(8)) dut1 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .man_req(man_req), .man_cmd(man_cmd), .man_gnt(mg[1]), .man_done(md[1]),
    .auto_req(auto_req), .auto_cmd(auto_cmd), .auto_gnt(ag[1]), .auto_done(ad[1]),
    .in_bits(ib[1]), .busy(bz[1]), .owner(ow[1]), .timeout(to[1])
  );

  always #5 clk = ~clk;

  // Stimulus per edge k (applied before edge k) and expected outputs after edge k.
  bit         s_mreq [N];
  bit         s_areq [N];
  logic [7:0] s_mcmd [N];
  logic [7:0] s_acmd [N];
  logic [1:0] s_mode [N];
  ob_t        ex [2][N];
  ob_t        rst_v;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic ob_t obs(input int d);
    ob_t o;
    o.ib = ib[d]; o.mg = mg[d]; o.md = md[d]; o.ag = ag[d];
    o.ad = ad[d]; o.busy = bz[d]; o.own = ow[d]; o.to = to[d];
    return o;
  endfunction

  task automatic check(input string tag, input ob_t got, input ob_t exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rc();
    logic [7:0] v;
    v = 8'($urandom);
    if (v[1:0] == 2'b00) v[0] = 1'b1;
    return v;
  endfunction

  function automatic bit req_at(input bit is_auto, input int j);
    if (j >= N) return 1'b0;
    return is_auto ? s_areq[j] : s_mreq[j];
  endfunction

  task automatic clr(input logic [1:0] m);
    for (int j = 0; j < N; j++) begin
      s_mreq[j] = 1'b0; s_areq[j] = 1'b0;
      s_mcmd[j] = rc(); s_acmd[j] = rc();
      s_mode[j] = m;
    end
  endtask

  // Transaction model. A grant decided at edge k drives the command after
  // edges k..x-1, where x is the first edge at or after k+HOLD with the
  // owner's request low, capped at k+mh. done (and timeout if capped) shows
  // after edge x, the gap lasts GAP cycles, and the next evaluation is at x+GAP+1.
  task automatic build(input int d, input int mh);
    int k;
    bit own;
    own = 1'b1;
    for (int j = 0; j < N; j++) ex[d][j] = '0;
    k = 0;
    while (k < N) begin
      bit me, ae, win, tmo;
      int x, nxt;
      logic [7:0] c;
      me = s_mreq[k] && (s_mode[k] != 2'b01);
      ae = s_areq[k] && (s_mode[k] != 2'b00);
      if (!me && !ae) begin
        ex[d][k].own = own;
        k++;
        continue;
      end
      if (me && ae) win = (s_mode[k] == 2'b11) ? !own : 1'b0;
      else          win = ae;
      own = win;
      c = win ? s_acmd[k] : s_mcmd[k];
      x = k + mh;
      tmo = 1'b1;
      if (c[1:0] == 2'b00) begin
        x = k;
        tmo = 1'b0;
      end else begin
        for (int j = k + HOLD; j <= k + mh; j++)
          if (!req_at(win, j)) begin x = j; tmo = 1'b0; break; end
      end
      nxt = x + GAP + 1;
      for (int j = k; j < nxt && j < N; j++) begin
        ex[d][j].own  = own;
        ex[d][j].busy = (j < x + GAP);
        if (j < x) ex[d][j].ib = c;
      end
      if (win) ex[d][k].ag = 1'b1; else ex[d][k].mg = 1'b1;
      if (x < N) begin
        if (win) ex[d][x].ad = 1'b1; else ex[d][x].md = 1'b1;
        ex[d][x].to = tmo;
      end
      k = nxt;
    end
  endtask

  // Resets both DUTs and plays the stimulus arrays. If rst_at >= 0, an
  // asynchronous reset is applied mid-cycle after that edge.
  task automatic run_seg(input string name, input int rst_at);
    build(0, 255);
    build(1, 8);
    rst = 1'b1;
    man_req = 1'b0; auto_req = 1'b0; man_cmd = 8'h00; auto_cmd = 8'h00; mode_sel = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("%s_reset_d%0d", name, d), obs(d), rst_v);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      mode_sel = s_mode[k];
      man_req  = s_mreq[k]; man_cmd  = s_mcmd[k];
      auto_req = s_areq[k]; auto_cmd = s_acmd[k];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        check($sformatf("%s_d%0d_c%0d", name, d, k), obs(d), ex[d][k]);
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check($sformatf("%s_async_d%0d", name, d), obs(d), rst_v);
        man_req = 1'b0; auto_req = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          for (int d = 0; d < 2; d++) check($sformatf("%s_held_d%0d", name, d), obs(d), rst_v);
        end
        #2 rst = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
          for (int d = 0; d < 2; d++) check($sformatf("%s_after_d%0d", name, d), obs(d), rst_v);
        end
        break;
      end
    end
  endtask

  initial begin
    rst_v = '0;
    rst_v.own = 1'b1;

    // Single manual command in manual-priority mode.
    clr(2'b10);
    s_mreq[0] = 1'b1; s_mcmd[0] = 8'h22;
    run_seg("man_basic", -1);

    // The auto request is held for 10 cycles, which extends the drive. The
    // MAX_HOLD=8 instance times out instead.
    clr(2'($urandom_range(1, 3)));
    for (int j = 0; j < N; j++) s_acmd[j] = 8'h42;
    for (int j = 0; j < 10; j++) s_areq[j] = 1'b1;
    run_seg("hold_ext", -1);

    // The manual request is stuck high, which forces timeout and then a re-grant.
    clr(2'b10);
    for (int j = 0; j < N; j++) s_mreq[j] = 1'b1;
    run_seg("stuck", -1);

    // Round-robin: manual first after reset, then auto.
    clr(2'b11);
    s_mreq[0] = 1'b1;
    for (int j = 0; j < 40; j++) s_areq[j] = 1'b1;
    run_seg("rr", -1);

    // Manual priority against a constant auto request.
    clr(2'b10);
    for (int j = 0; j < N; j++) begin
      s_areq[j] = 1'b1;
      s_mreq[j] = ($urandom_range(0, 3) != 0);
    end
    run_seg("man_prio", -1);

    // Auto-only mode ignores the manual request.
    clr(2'b01);
    for (int j = 0; j < N; j++) s_mreq[j] = 1'b1;
    run_seg("auto_only", -1);

    // Null command, then a real one that must wait out the gap.
    clr(2'b01);
    for (int j = 0; j < 6; j++) s_areq[j] = 1'b1;
    s_acmd[0] = {6'($urandom), 2'b00};
    run_seg("null_cmd", -1);

    // Mode switch from 10 to 01 during a manual drive.
    clr(2'b01);
    for (int j = 0; j < 3; j++) s_mode[j] = 2'b10;
    s_mreq[0] = 1'b1; s_mreq[1] = 1'b1;
    for (int j = 8; j < 20; j++) s_mreq[j] = 1'b1;
    for (int j = 2; j < 30; j++) s_areq[j] = 1'b1;
    run_seg("mode_chg", -1);

    // Random traffic: persistent request levels, arbitrary command bytes
    // (nulls included), and a mode change halfway through.
    for (int r = 0; r < 4; r++) begin
      bit m, a;
      logic [1:0] m1, m2;
      m = 1'b0; a = 1'b0;
      m1 = 2'($urandom_range(0, 3));
      m2 = 2'($urandom_range(0, 3));
      clr(m1);
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 3) == 0) m = !m;
        if ($urandom_range(0, 3) == 0) a = !a;
        s_mreq[j] = m; s_areq[j] = a;
        s_mcmd[j] = 8'($urandom); s_acmd[j] = 8'($urandom);
        if (j >= N / 2) s_mode[j] = m2;
      end
      run_seg($sformatf("rand%0d", r), -1);
    end

    // Asynchronous reset in the middle of driving 0x0B.
    clr(2'b10);
    s_mreq[0] = 1'b1; s_mcmd[0] = 8'h0B;
    run_seg("rst_mid", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
